// File: rtl/cr_kme_int_servicer_if.sv
// cr_kme_int_servicer_if: servicer bus; slave = servicer side (kme status/control in, register write + counters out), master = driver side
interface cr_kme_int_servicer_if;
  logic        kme_interrupt;
  logic [4:0]  interrupt_status;
  logic        enable;
  logic [4:0]  clr_mask;
  logic        cnt_clr;
  logic        wr_stb;
  logic [31:0] wr_data;
  logic [10:0] reg_addr;
  logic [39:0] evt_cnt;
  logic [7:0]  spurious_cnt;
  logic        busy;
  modport slave (
    input  kme_interrupt, interrupt_status, enable, clr_mask, cnt_clr,
    output wr_stb, wr_data, reg_addr, evt_cnt, spurious_cnt, busy
  );
  modport master (
    output kme_interrupt, interrupt_status, enable, clr_mask, cnt_clr,
    input  wr_stb, wr_data, reg_addr, evt_cnt, spurious_cnt, busy
  );
endinterface

// File: rtl/cr_kme_int_servicer.sv
// cr_kme_int_servicer: services KME interrupts by W1C-clearing masked status bits; ports clk, rst_n (async low), bus (slave modport: status/control in, write strobe/data/addr, counters, busy out)
module cr_kme_int_servicer #(
  parameter logic [10:0] INT_STATUS_ADDR = 11'h37C,
  parameter int          SETTLE_CYCLES   = 2,
  parameter int          HOLDOFF_CYCLES  = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  cr_kme_int_servicer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CAPTURE, WRITE, SETTLE, HOLDOFF} state_t;
  state_t          state_q, state_d;
  logic [4:0]      cap_q, cap_d;
  logic [7:0]      timer_q, timer_d;
  logic [4:0][7:0] evt_q, evt_d;
  logic [7:0]      spur_q, spur_d;
  logic [4:0]      cap_now;
  assign cap_now = bus.interrupt_status & bus.clr_mask;
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    timer_d = timer_q;
    evt_d   = evt_q;
    spur_d  = spur_q;
    case (state_q)
      IDLE:    state_d = (bus.kme_interrupt && bus.enable) ? CAPTURE : IDLE;
      CAPTURE: begin
        cap_d   = cap_now;
        state_d = |cap_now ? WRITE : HOLDOFF;
        timer_d = 8'(HOLDOFF_CYCLES);
        spur_d  = (|cap_now || spur_q == 8'hFF) ? spur_q : spur_q + 8'd1;
      end
      WRITE: begin
        for (int i = 0; i < 5; i++)
          evt_d[i] = (cap_q[i] && evt_q[i] != 8'hFF) ? evt_q[i] + 8'd1 : evt_q[i];
        state_d = SETTLE;
        timer_d = 8'(SETTLE_CYCLES - 1);
      end
      SETTLE, HOLDOFF: begin
        state_d = (timer_q == 8'd0) ? IDLE : state_q;
        timer_d = (timer_q == 8'd0) ? 8'd0 : timer_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    evt_d  = bus.cnt_clr ? '0 : evt_d;
    spur_d = bus.cnt_clr ? '0 : spur_d;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cap_q   <= '0;
      timer_q <= '0;
      evt_q   <= '0;
      spur_q  <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      timer_q <= timer_d;
      evt_q   <= evt_d;
      spur_q  <= spur_d;
    end
  assign bus.wr_stb       = state_q == WRITE;
  assign bus.wr_data      = bus.wr_stb ? {27'b0, cap_q} : '0;
  assign bus.reg_addr     = bus.wr_stb ? INT_STATUS_ADDR : '0;
  assign bus.evt_cnt      = evt_q;
  assign bus.spurious_cnt = spur_q;
  assign bus.busy         = state_q != IDLE;
endmodule

// File: tb/tb_cr_kme_int_servicer.sv
// tb_cr_kme_int_servicer: table-driven and directed checks of the KME interrupt servicer
module tb_cr_kme_int_servicer;
  logic clk = 0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  cr_kme_int_servicer_if bus();
  cr_kme_int_servicer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [4:0]  st;
    logic [4:0]  mk;
    int          stb;
    logic [31:0] data;
    logic [39:0] evt;
    logic [7:0]  spur;
    int          busy;
  } vec_t;
  vec_t vt[6];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_clr();
    bus.cnt_clr = 1;
    tick();
    bus.cnt_clr = 0;
  endtask
  task automatic run_seq(output int n, output int stb_cnt, output int stb_at,
                         output logic [31:0] dat, output logic [10:0] adr, output bit bad);
    n = 0; stb_cnt = 0; stb_at = -1; dat = '0; adr = '0; bad = 0;
    while (bus.busy && n < 100) begin
      if (bus.wr_stb) begin
        stb_cnt++;
        stb_at = n;
        dat = bus.wr_data;
        adr = bus.reg_addr;
      end else if (bus.wr_data != 0 || bus.reg_addr != 0) bad = 1;
      n++;
      tick();
    end
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < 100) begin
      n++;
      tick();
    end
    chk(name, bus.busy, 0);
  endtask
  initial begin
    int n, sc, sa, pulses;
    logic [31:0] dat;
    logic [10:0] adr;
    bit bad;
    vt[0] = '{5'b00101, 5'h1F,    1, 32'h05, 40'h0000010001, 8'd0, 4};
    vt[1] = '{5'b00010, 5'b11101, 0, 32'h00, 40'h0,          8'd1, 18};
    vt[2] = '{5'b11111, 5'h1F,    1, 32'h1F, 40'h0101010101, 8'd0, 4};
    vt[3] = '{5'b10001, 5'b10000, 1, 32'h10, 40'h0100000000, 8'd0, 4};
    vt[4] = '{5'b00000, 5'h1F,    0, 32'h00, 40'h0,          8'd1, 18};
    vt[5] = '{5'b01010, 5'b01000, 1, 32'h08, 40'h0001000000, 8'd0, 4};
    rst_n = 0;
    bus.kme_interrupt = 1; bus.enable = 1; bus.interrupt_status = 5'h1F;
    bus.clr_mask = 5'h1F; bus.cnt_clr = 0;
    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_wr_stb", bus.wr_stb, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_reg_addr", bus.reg_addr, 0);
    chk("rst_evt_cnt", bus.evt_cnt, 0);
    chk("rst_spurious_cnt", bus.spurious_cnt, 0);
    bus.kme_interrupt = 0;
    rst_n = 1;
    tick();
    chk("post_rst_idle", bus.busy, 0);
    for (int v = 0; v < 6; v++) begin
      pulse_clr();
      bus.interrupt_status = vt[v].st;
      bus.clr_mask = vt[v].mk;
      bus.enable = 1;
      bus.kme_interrupt = 1;
      tick();
      bus.kme_interrupt = 0;
      run_seq(n, sc, sa, dat, adr, bad);
      chk($sformatf("v%0d_busy_cycles", v), n, vt[v].busy);
      chk($sformatf("v%0d_stb_count", v), sc, vt[v].stb);
      if (sc == 1) chk($sformatf("v%0d_stb_latency", v), sa, 1);
      chk($sformatf("v%0d_wr_data", v), dat, vt[v].data);
      chk($sformatf("v%0d_reg_addr", v), adr, vt[v].stb != 0 ? 11'h37C : 11'h0);
      chk($sformatf("v%0d_idle_bus_zero", v), bad, 0);
      chk($sformatf("v%0d_evt_cnt", v), bus.evt_cnt, vt[v].evt);
      chk($sformatf("v%0d_spurious_cnt", v), bus.spurious_cnt, vt[v].spur);
    end
    bus.enable = 0; bus.kme_interrupt = 1; bus.interrupt_status = 5'b00001; bus.clr_mask = 5'h1F;
    bad = 0;
    repeat (5) begin tick(); if (bus.busy || bus.wr_stb) bad = 1; end
    chk("enable_low_idle", bad, 0);
    pulse_clr();
    bus.enable = 1;
    tick();
    bus.enable = 0;
    run_seq(n, sc, sa, dat, adr, bad);
    chk("enable_drop_completes", sc, 1);
    chk("enable_drop_evt", bus.evt_cnt, 40'h1);
    bad = 0;
    repeat (5) begin tick(); if (bus.busy) bad = 1; end
    chk("enable_drop_stays_idle", bad, 0);
    bus.kme_interrupt = 0;
    bus.enable = 1; bus.interrupt_status = 5'b00100; bus.kme_interrupt = 1;
    tick();
    bus.kme_interrupt = 0;
    tick();
    chk("collide_in_write", bus.wr_stb, 1);
    bus.cnt_clr = 1;
    tick();
    bus.cnt_clr = 0;
    chk("collide_evt_cleared", bus.evt_cnt, 0);
    chk("collide_spur_cleared", bus.spurious_cnt, 0);
    wait_idle("collide_idle");
    bus.interrupt_status = 5'b00101; bus.kme_interrupt = 1;
    tick();
    tick();
    chk("late_first_stb", bus.wr_stb, 1);
    chk("late_first_data", bus.wr_data, 32'h5);
    bus.interrupt_status = 5'b01101;
    tick();
    bus.interrupt_status = 5'b01000;
    n = 0;
    while (!bus.wr_stb && n < 20) begin n++; tick(); end
    chk("late_second_stb", bus.wr_stb, 1);
    chk("late_second_data", bus.wr_data, 32'h8);
    bus.kme_interrupt = 0;
    wait_idle("late_idle");
    chk("late_evt", bus.evt_cnt, 40'h0001010001);
    bus.interrupt_status = 5'b00001; bus.kme_interrupt = 1;
    tick();
    tick();
    chk("rst_write_stb_high", bus.wr_stb, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_write_stb_drop", bus.wr_stb, 0);
    chk("rst_write_busy", bus.busy, 0);
    chk("rst_write_evt", bus.evt_cnt, 0);
    chk("rst_write_spur", bus.spurious_cnt, 0);
    bus.kme_interrupt = 0;
    tick();
    rst_n = 1;
    tick();
    chk("rst_write_after_idle", bus.busy, 0);
    pulse_clr();
    bus.interrupt_status = 5'b10000; bus.clr_mask = 5'h1F; bus.kme_interrupt = 1;
    pulses = 0; n = 0;
    while (pulses < 300 && n < 5000) begin
      tick();
      if (bus.wr_stb) pulses++;
      n++;
    end
    chk("sat_pulses", pulses, 300);
    bus.kme_interrupt = 0;
    wait_idle("sat_idle");
    chk("sat_evt", bus.evt_cnt, 40'hFF00000000);
    chk("sat_spur", bus.spurious_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cr_kme_int_servicer.md
CR_KME_INT_SERVICER -- requirements
Module: cr_kme_int_servicer

Interface
REQ-001 Parameters: INT_STATUS_ADDR, default 11'h37C, the address of the KME interrupt-status W1C register.
REQ-002 Parameters: SETTLE_CYCLES, default 2, cycles to wait after a clear write before re-sampling kme_interrupt; legal range 1..15.
REQ-003 Parameters: HOLDOFF_CYCLES, default 16, back-off after a spurious interrupt; legal range 1..255.
REQ-004 Clocking: one clock, clk; reset rst_n is asynchronous and active-low.
REQ-005 clk  in  1  block clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 kme_interrupt  in  1  registered level interrupt from the KME interrupt handler.
REQ-008 interrupt_status  in  5  sticky status bits from the same handler.
REQ-009 enable  in  1  servicing enable.
REQ-010 clr_mask  in  5  per-bit permission to clear; 0 leaves that bit sticky for software.
REQ-011 cnt_clr  in  1  synchronous clear of all counters.
REQ-012 wr_stb  out  1  single-cycle register write strobe.
REQ-013 wr_data  out  32  write data, {27'b0, clear bits}.
REQ-014 reg_addr  out  11  write address.
REQ-015 evt_cnt  out  40  five 8-bit event counters; bit i occupies [8i+7:8i].
REQ-016 spurious_cnt  out  8  count of interrupts with nothing clearable.
REQ-017 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, CAPTURE, WRITE, SETTLE and HOLDOFF, encoded in registered state.
REQ-019 IDLE -> CAPTURE SHALL occur when kme_interrupt & enable is sampled high; otherwise the FSM SHALL remain in IDLE.
REQ-020 CAPTURE SHALL register cap = interrupt_status & clr_mask for one cycle.
REQ-021 From CAPTURE, the FSM SHALL go to WRITE if cap != 0, else to HOLDOFF.
REQ-022 WRITE SHALL last exactly one cycle with wr_stb=1, reg_addr=INT_STATUS_ADDR and wr_data={27'b0,cap}, then go to SETTLE.
REQ-023 Outside WRITE, wr_stb SHALL be 0, and wr_data and reg_addr SHALL be 0.
REQ-024 In WRITE, evt_cnt[i] SHALL increment for every i with cap[i]=1, saturating at 8'hFF with no wrap.
REQ-025 SETTLE SHALL count SETTLE_CYCLES cycles, then go to IDLE; kme_interrupt SHALL be ignored while counting.
REQ-026 On entry to HOLDOFF, spurious_cnt SHALL increment, saturating at 8'hFF.
REQ-027 HOLDOFF SHALL wait HOLDOFF_CYCLES cycles, then go to IDLE.
REQ-028 Minimum latency SHALL be: kme_interrupt high in cycle N gives wr_stb high in cycle N+2.
REQ-029 Deasserting enable mid-sequence SHALL NOT abort the sequence; the current sequence completes and the FSM then stays in IDLE.
REQ-030 When cnt_clr coincides with an increment, the clear SHALL win and all counters read 0 on the next cycle.
REQ-031 Status bits that rise after CAPTURE SHALL NOT be written; they are serviced by the next sequence.
REQ-032 At most one write SHALL be issued per sequence.
REQ-033 busy SHALL be 0 in IDLE and 1 in every other state.

Reset
REQ-034 On rst_n low the block SHALL asynchronously enter IDLE, with wr_stb=0, wr_data=0, reg_addr=0, evt_cnt=0, spurious_cnt=0, busy=0 and all timers 0.
REQ-035 Reset during WRITE SHALL drop wr_stb immediately, without waiting for a clock edge.
REQ-036 After rst_n rises, the first transition out of IDLE SHALL occur no earlier than the first clock edge.

Verification
REQ-037 Basic service: status=5'b00101, clr_mask=5'h1F, kme_interrupt rises at cycle N -> wr_stb at N+2, wr_data=32'h5, reg_addr=11'h37C, evt_cnt[0]=1, evt_cnt[2]=1, busy low at N+5.
REQ-038 Masked: status=5'b00010, clr_mask=5'b11101 -> no wr_stb, spurious_cnt=1, busy high for 1+1+16 cycles.
REQ-039 Saturation: 300 services of bit 4 -> evt_cnt[39:32]=8'hFF, other counters 0.
REQ-040 Clear/increment collision: cnt_clr asserted in the WRITE cycle -> all counters 0 on the next cycle.
REQ-041 Reset mid-WRITE: rst_n dropped while wr_stb=1 -> wr_stb=0 before the next edge, FSM in IDLE, all counters 0.
REQ-042 Late status bit: bit 3 rises in the cycle after CAPTURE -> the first write has wr_data[3]=0, and a second sequence clears bit 3 after SETTLE.
